// File: rtl/we_pkg.sv
// we_pkg: shared types and constants for the write-enable write sequencer.
package we_pkg;

  localparam int WE_DATA_W = 64;

  localparam logic WE_WN_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    GAP
  } we_wr_state_t;

endpackage

// File: rtl/we_wr_fifo.sv
// we_wr_fifo: synchronous request FIFO with registered full/empty and a head view.
module we_wr_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp, rp;
  logic [CW-1:0]     cnt;
  logic              do_push, do_pop;

  assign full    = cnt == CW'(DEPTH);
  assign empty   = cnt == '0;
  assign head    = mem[rp];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= data;
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= wp + AW'(do_push);
      rp  <= rp + AW'(do_pop);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/we_wr_ctrl.sv
// we_wr_ctrl: buffers write requests and issues single-cycle wn strobes with a minimum gap.
// Optional WE_WR_CTRL_READBACK_EN adds rdata/rb_err to verify each captured word.
module we_wr_ctrl
  import we_pkg::*;
#(
  parameter int DATA_W = WE_DATA_W,
  parameter int DEPTH  = 2,
  parameter int GAP    = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              wn,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic [CNT_W-1:0]  wr_count
`ifdef WE_WR_CTRL_READBACK_EN
  ,
  input  logic [DATA_W-1:0] rdata,
  output logic              rb_err
`endif
);

  localparam int              GW    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0]   GLOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  we_wr_state_t      state, state_n;
  logic [GW-1:0]     gcnt, gcnt_n;
  logic              wn_n;
  logic [DATA_W-1:0] wdata_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              full, empty, push, pop;
  logic [DATA_W-1:0] head;

  assign s_ready = rst_n && !full;
  assign push    = s_valid && s_ready;
  assign busy    = (state != IDLE) || !empty;

  we_wr_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .data (s_data),
    .head (head),
    .full (full),
    .empty(empty)
  );

  // a strobe issues whenever the FIFO has data and no gap is still owed
  always_comb begin
    pop     = !empty && (state == IDLE || (state == WRITE && GAP == 0) ||
                         (state == we_pkg::GAP && gcnt == '0));
    state_n = pop ? WRITE :
              (state == WRITE && GAP > 0) ? we_pkg::GAP :
              (state == we_pkg::GAP && gcnt != '0) ? we_pkg::GAP : IDLE;
    gcnt_n  = (state == WRITE) ? GLOAD : (state == we_pkg::GAP) ? gcnt - 1'b1 : gcnt;
    wn_n    = pop ? WE_WN_ACTIVE : ~WE_WN_ACTIVE;
    wdata_n = pop ? head : wdata;
    cnt_n   = wr_count + CNT_W'(pop);
  end

  // state and registered outputs; reset ends any strobe in progress
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gcnt     <= '0;
      wn       <= ~WE_WN_ACTIVE;
      wdata    <= '0;
      wr_count <= '0;
    end else begin
      state    <= state_n;
      gcnt     <= gcnt_n;
      wn       <= wn_n;
      wdata    <= wdata_n;
      wr_count <= cnt_n;
    end
  end

`ifdef WE_WR_CTRL_READBACK_EN
  logic              chk;
  logic [DATA_W-1:0] last;

  // remember the word just strobed and compare it against the register one cycle later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk    <= 1'b0;
      last   <= '0;
      rb_err <= 1'b0;
    end else begin
      chk    <= wn == WE_WN_ACTIVE;
      last   <= wdata;
      rb_err <= rb_err || (chk && rdata != last);
    end
  end
`endif

endmodule
